fifo_stream_reader: RTL
=======================

// Module: fifo_stream_reader
// PURPOSE
//   Read-side drain engine for the synchronous FIFO (we/din/re/dout/empty/full,
//   registered dout one cycle after an accepted re). Pops words from the FIFO
//   and presents them as a valid/ready stream framed into fixed-length packets
//   (m_last on final word). Sits between the capture FIFO and the packetizer.
//   A 2-entry skid buffer absorbs read latency; sustains 1 word/cycle.
// PARAMETERS
//   DATA_WIDTH  64   width of FIFO words and m_data
//   PKT_WORDS   256  words per packet (>=2); m_last on word PKT_WORDS-1
//   CNT_WIDTH   32   width of pkt_count
// PORTS
//   clk        in   1           system clock, all logic on posedge
//   rst_n      in   1           asynchronous, active-low reset
//   enable     in   1           1 = drain FIFO; 0 = stop at next packet boundary
//   fifo_empty in   1           FIFO empty flag
//   fifo_re    out  1           FIFO read enable (combinational)
//   fifo_dout  in   DATA_WIDTH  FIFO read data, valid cycle after accepted re
//   m_data     out  DATA_WIDTH  stream data (head of skid buffer)
//   m_valid    out  1           stream valid
//   m_ready    in   1           stream ready from downstream
//   m_last     out  1           final word of packet
//   busy       out  1           state != IDLE
//   pkt_count  out  CNT_WIDTH   packets completed since reset, wraps 2^CNT_WIDTH
// BEHAVIOUR
//   Reset (rst_n=0, async): state IDLE, buffer occ=0, rd_pend=0, rd_idx=0,
//     wr_idx=0, pkt_count=0; m_valid=0, m_last=0, busy=0, fifo_re=0, m_data=0.
//   pop = m_valid & m_ready. rd_pend = registered (fifo_re & !fifo_empty).
//   fifo_re = issue_ok & !fifo_empty & ((occ + rd_pend - pop) < 2);
//     guarantees buffer never overflows; no reads issued while fifo_empty.
//   Capture: when rd_pend=1, fifo_dout written into buffer at that clock edge.
//     Latency: re accepted at edge N -> m_valid high from edge N+1 onward.
//   m_valid = (occ != 0); m_data/m_last held stable while m_valid & !m_ready.
//   Simultaneous capture and pop: occ unchanged, order preserved (FIFO order).
//   rd_idx: counts words issued in current packet, 0..PKT_WORDS-1, wraps.
//   wr_idx: counts words popped; m_last = m_valid & (wr_idx == PKT_WORDS-1);
//     pop with m_last -> wr_idx=0, pkt_count+1 (wraps to 0 at max).
//   FSM:
//     IDLE : issue_ok=0. enable=1 -> RUN.
//     RUN  : issue_ok=1. enable=0 -> STOP (same edge).
//     STOP : issue_ok = (rd_idx != 0); reads continue only to complete the
//            current packet. When rd_idx==0 & rd_pend=0 & occ=0 -> IDLE.
//            enable=1 again in STOP -> RUN (no words lost or duplicated).
//   FIFO empty mid-packet: m_valid drops once buffer drains; packet resumes
//     when data arrives; framing (wr_idx) unaffected by gaps.
//   Reset mid-operation: buffered and in-flight words discarded; framing
//     restarts at word 0; FIFO is reset by its own rst.
//   enable=0 in IDLE with data in FIFO: fifo_re stays 0.
// TESTING
//   1 PKT_WORDS=4, FIFO holds 1..8, enable=1, m_ready=1 -> beats 1..8 in order,
//     m_last on 4 and 8, pkt_count=2, busy=1 until enable=0.
//   2 FIFO holds 64 words, m_ready=1 -> 64 beats on 64 consecutive cycles
//     after first m_valid (no bubbles).
//   3 m_ready=0 for 10 cycles with FIFO full -> at most 2 fifo_re accepted,
//     m_data stable; release -> no loss, no duplicates, order preserved.
//   4 PKT_WORDS=4, enable falls after 2nd word issued -> words 3,4 delivered,
//     m_last on 4, then fifo_re=0, remaining FIFO words untouched, busy->0.
//   5 FIFO empties after word 2 of 4, refilled 5 cycles later -> m_valid gap,
//     words 3,4 follow with m_last on 4; pkt_count increments once.
//   6 rst_n=0 asynchronously with occ=2 mid-packet -> m_valid=0, pkt_count=0
//     immediately; after release next packet's m_last on 4th word.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream framed
// into fixed-length packets, using a 2-entry skid buffer to hide read latency.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int PKT_WORDS  = 256,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_re,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int IDX_W = (PKT_WORDS > 2) ? $clog2(PKT_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t                state, state_nxt;
  logic                  issue_ok;
  logic [1:0]            occ;
  logic                  rd_pend;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;
  logic                  rd_accept;
  logic [2:0]            fill_after;

  assign pop       = m_valid & m_ready;
  assign m_valid   = (occ != 2'd0);
  assign m_data    = head_q;
  assign m_last    = m_valid & (wr_idx == LAST_IDX);
  assign busy      = (state != IDLE);

  // Projected occupancy once the in-flight read lands and this cycle's pop retires.
  assign fill_after = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
  assign fifo_re    = issue_ok & ~fifo_empty & (fill_after < 3'd2);
  assign rd_accept  = fifo_re & ~fifo_empty;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    issue_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        issue_ok = 1'b1;
        if (!enable) state_nxt = STOP;
      end
      STOP: begin
        issue_ok = (rd_idx != '0);
        if (enable) begin
          state_nxt = RUN;
        end else if ((rd_idx == '0) && !rd_pend && (occ == 2'd0)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_pend <= 1'b0;
      rd_idx  <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_accept;
      if (rd_accept) rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
    end
  end

  // NOTE: the two buffer entries are reset because m_data must read zero out of reset; larger storage would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ    <= 2'd0;
    end else begin
      case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= fifo_dout;
          else             tail_q <= fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          // Capture and pop together: occupancy holds, arrival goes behind the survivor.
          if (occ == 2'd1) begin
            head_q <= fifo_dout;
          end else begin
            head_q <= tail_q;
            tail_q <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      pkt_count <= '0;
    end else if (pop) begin
      if (wr_idx == LAST_IDX) begin
        wr_idx    <= '0;
        pkt_count <= pkt_count + 1'b1;
      end else begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

endmodule
